instruction_fetch_sequencer: RTL and testbench

Fetch/decode control stage that sits directly downstream of the 4-bit program counter in the 8-bit CPU. It consumes current_address and holds a loadable 16x8 program memory. It latches each instruction into an instruction register, decodes it, and drives the counter's increment/jump/address_input controls. It runs a fixed 3-cycle FETCH/DECODE/EXECUTE sequence and exports opcode/operand to the datapath.

---
 rtl/instruction_fetch_sequencer_pkg.sv | 57 +++++
 rtl/instruction_fetch_sequencer_if.sv | 44 ++++
 rtl/instruction_fetch_sequencer_program_rom_16x8.sv | 46 ++++
 rtl/instruction_fetch_sequencer.sv | 106 ++++++++++
 tb/tb_instruction_fetch_sequencer.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch/decode sequencer.
// Contents:
//   ADDR_W/DATA_W/DEPTH/OP_W  - program address, instruction and opcode widths
//   OP_NOP..OP_HLT            - opcode constants (9..D are reserved and act as NOP)
//   state_e                   - sequencer state encoding
//   op_kind_e / decode_kind() - reduces an opcode to the way it drives the PC
package instruction_fetch_sequencer_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int OP_W   = DATA_W - ADDR_W;

    localparam logic [OP_W-1:0] OP_NOP = 4'h0;
    localparam logic [OP_W-1:0] OP_LDA = 4'h1;
    localparam logic [OP_W-1:0] OP_ADD = 4'h2;
    localparam logic [OP_W-1:0] OP_SUB = 4'h3;
    localparam logic [OP_W-1:0] OP_STA = 4'h4;
    localparam logic [OP_W-1:0] OP_LDI = 4'h5;
    localparam logic [OP_W-1:0] OP_JMP = 4'h6;
    localparam logic [OP_W-1:0] OP_JZ  = 4'h7;
    localparam logic [OP_W-1:0] OP_JC  = 4'h8;
    localparam logic [OP_W-1:0] OP_OUT = 4'hE;
    localparam logic [OP_W-1:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_HALT
    } state_e;

    // How an instruction affects the program counter in EXECUTE.
    typedef enum logic [2:0] {
        K_STEP,   // advance to the next address
        K_JMP,    // unconditional jump to operand
        K_JZ,     // jump if zero_flag, else step
        K_JC,     // jump if carry_flag, else step
        K_HLT     // stop; PC untouched
    } op_kind_e;

    function automatic op_kind_e decode_kind(input logic [OP_W-1:0] op);
        op_kind_e kind;
        case (op)
            OP_JMP:  kind = K_JMP;
            OP_JZ:   kind = K_JZ;
            OP_JC:   kind = K_JC;
            OP_HLT:  kind = K_HLT;
            OP_NOP, OP_LDA, OP_ADD, OP_SUB,
            OP_STA, OP_LDI, OP_OUT: kind = K_STEP;
            default: kind = K_STEP;   // reserved opcodes behave as NOP
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/instruction_fetch_sequencer_if.sv
// Bundle of every non-clock signal of the fetch sequencer.
//   master modport: the sequencer (receives run/program bus/PC/flags,
//                   drives PC controls and decoded instruction fields)
//   slave modport : the surrounding CPU / test environment
// Signals:
//   run, prog_we, prog_addr, prog_data  - control and program loading
//   current_address, zero_flag, carry_flag - from PC and ALU
//   increment, jump, address_input      - to PC
//   opcode, operand, exec_valid         - to datapath
//   halted, fault                       - status
interface instruction_fetch_sequencer_if;
    import instruction_fetch_sequencer_pkg::*;

    logic              run;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic [ADDR_W-1:0] current_address;
    logic              zero_flag;
    logic              carry_flag;
    logic              increment;
    logic              jump;
    logic [ADDR_W-1:0] address_input;
    logic [OP_W-1:0]   opcode;
    logic [ADDR_W-1:0] operand;
    logic              exec_valid;
    logic              halted;
    logic              fault;

    modport master (
        input  run, prog_we, prog_addr, prog_data,
        input  current_address, zero_flag, carry_flag,
        output increment, jump, address_input,
        output opcode, operand, exec_valid, halted, fault
    );

    modport slave (
        output run, prog_we, prog_addr, prog_data,
        output current_address, zero_flag, carry_flag,
        input  increment, jump, address_input,
        input  opcode, operand, exec_valid, halted, fault
    );

endinterface

// File: rtl/instruction_fetch_sequencer_program_rom_16x8.sv
// Loadable 16x8 program memory with a registered read port that doubles
// as the instruction register.
// Ports:
//   clk, reset  - clock; async active-high reset (clears IR only)
//   we/waddr/wdata - synchronous write port (caller gates legality)
//   re/raddr    - when re is high, IR loads mem[raddr] at the clock edge
//   ir_q        - instruction register
module program_rom_16x8
    import instruction_fetch_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] ir_q
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] ir_d;

    // NOTE: the array has no reset -- program contents must survive a CPU
    // reset, and a resettable array would not map onto RAM cells.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        ir_d = re ? mem_q[raddr] : ir_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_q <= '0;
        end else begin
            ir_q <= ir_d;
        end
    end

endmodule

// File: rtl/instruction_fetch_sequencer.sv
// Fetch/decode control stage for the 8-bit CPU. Runs a fixed
// FETCH -> DECODE -> EXECUTE sequence per instruction, drives the program
// counter controls in EXECUTE and exports opcode/operand to the datapath.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-high reset (shared with the PC)
//   bus   - instruction_fetch_sequencer_if.master (see interface file)
module instruction_fetch_sequencer
    import instruction_fetch_sequencer_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    instruction_fetch_sequencer_if.master bus
);

    state_e            state_q, state_d;
    logic              fault_q, fault_d;
    logic              halted_q, halted_d;
    logic              exec_valid_q, exec_valid_d;
    logic [DATA_W-1:0] ir_q;

    op_kind_e          kind;
    logic              taken;
    logic              step;
    logic              at_top;
    logic              in_exec;
    logic              prog_ok;

    // Writes are only legal while nothing is being fetched, which also
    // rules out a read/write collision on the same address.
    assign prog_ok = (state_q == ST_IDLE) || (state_q == ST_HALT);

    program_rom_16x8 u_rom (
        .clk   (clk),
        .reset (reset),
        .we    (bus.prog_we && prog_ok),
        .waddr (bus.prog_addr),
        .wdata (bus.prog_data),
        .re    (state_q == ST_FETCH),
        .raddr (bus.current_address),
        .ir_q  (ir_q)
    );

    // NOTE: every signal written here gets a value before any branch so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        kind    = decode_kind(ir_q[DATA_W-1 -: OP_W]);
        in_exec = (state_q == ST_EXECUTE);
        at_top  = (bus.current_address == '1);
        taken   = (kind == K_JMP)
               || (kind == K_JZ && bus.zero_flag)
               || (kind == K_JC && bus.carry_flag);
        step    = (kind != K_HLT) && !taken;
        state_d = state_q;
        fault_d = fault_q;

        case (state_q)
            ST_IDLE:    if (bus.run) state_d = ST_FETCH;
            ST_FETCH:   state_d = ST_DECODE;
            ST_DECODE:  state_d = ST_EXECUTE;
            ST_EXECUTE: begin
                if (kind == K_HLT) begin
                    state_d = ST_HALT;
                end else if (step && at_top) begin
                    // Stepping past the last address would wrap the PC.
                    state_d = ST_HALT;
                    fault_d = 1'b1;
                end else begin
                    state_d = bus.run ? ST_FETCH : ST_IDLE;
                end
            end
            ST_HALT:    state_d = ST_HALT;
            default:    state_d = ST_IDLE;
        endcase

        // Status outputs are registered copies of the upcoming state.
        halted_d     = (state_d == ST_HALT);
        exec_valid_d = (state_d == ST_EXECUTE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            fault_q      <= 1'b0;
            halted_q     <= 1'b0;
            exec_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fault_q      <= fault_d;
            halted_q     <= halted_d;
            exec_valid_q <= exec_valid_d;
        end
    end

    // PC controls follow the flags combinationally during EXECUTE; the PC
    // commits them at the edge that ends EXECUTE.
    assign bus.jump          = in_exec && taken;
    assign bus.increment     = in_exec && step && !at_top;
    assign bus.opcode        = ir_q[DATA_W-1 -: OP_W];
    assign bus.operand       = ir_q[ADDR_W-1:0];
    assign bus.address_input = ir_q[ADDR_W-1:0];
    assign bus.exec_valid    = exec_valid_q;
    assign bus.halted        = halted_q;
    assign bus.fault         = fault_q;

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Self-checking bench for instruction_fetch_sequencer. A 4-bit program
// counter model is driven by the DUT's PC controls; an instruction-level
// reference model (memory image + reference PC) predicts every EXECUTE.
module tb_instruction_fetch_sequencer;
    import instruction_fetch_sequencer_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    instruction_fetch_sequencer_if ifc ();

    instruction_fetch_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    // Program counter sitting upstream of the sequencer.
    logic [3:0] pc;
    always @(posedge clk or posedge reset) begin
        if (reset)              pc <= 4'h0;
        else if (ifc.jump)      pc <= ifc.address_input;
        else if (ifc.increment) pc <= pc + 4'd1;
    end
    assign ifc.current_address = pc;

    // Reference model state.
    logic [7:0] mem_ref [16];
    logic [3:0] pc_ref;
    bit         ref_halted;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".increment"},  ifc.increment,     0);
        check({tag, ".jump"},       ifc.jump,          0);
        check({tag, ".exec_valid"}, ifc.exec_valid,    0);
        check({tag, ".halted"},     ifc.halted,        0);
        check({tag, ".fault"},      ifc.fault,         0);
        check({tag, ".opcode"},     ifc.opcode,        0);
        check({tag, ".operand"},    ifc.operand,       0);
        check({tag, ".addr_in"},    ifc.address_input, 0);
    endtask

    task automatic write_mem(input logic [3:0] a, input logic [7:0] d);
        ifc.prog_we   = 1'b1;
        ifc.prog_addr = a;
        ifc.prog_data = d;
        tick();
        ifc.prog_we   = 1'b0;
        mem_ref[a]    = d;
    endtask

    task automatic do_reset(input string tag);
        ifc.run = 1'b0;
        reset   = 1'b1;
        tick();
        tick();
        reset   = 1'b0;
        pc_ref  = 4'h0;
        ref_halted = 1'b0;
        check_idle_outputs({tag, ".rst"});
        check({tag, ".rst.pc"}, ifc.current_address, 0);
    endtask

    // Runs from IDLE with PC=0, up to max_instr instructions.
    //   rand_flags : draw zero/carry flags per instruction, else use zf_v/cf_v
    //   stop_run   : drop run at the start of the last instruction
    //   blk_write  : attempt a write of AA to address 3 while the first
    //                instruction is in flight (must be ignored)
    task automatic run_program(input string name, input int max_instr,
                               input bit rand_flags, input bit zf_v, input bit cf_v,
                               input bit stop_run, input bit blk_write);
        logic [7:0] ins;
        logic [3:0] op, arg, next_pc;
        bit         e_jump, e_inc, e_fault, e_hlt;
        int         cycles;
        ifc.run = 1'b1;
        for (int n = 0; n < max_instr; n++) begin
            ifc.zero_flag  = rand_flags ? 1'($urandom_range(0, 1)) : zf_v;
            ifc.carry_flag = rand_flags ? 1'($urandom_range(0, 1)) : cf_v;
            if (stop_run && n > 0 && n == max_instr - 1) ifc.run = 1'b0;
            cycles = 0;
            do begin
                tick();
                cycles++;
                if (blk_write && n == 0 && cycles == 1) begin
                    ifc.prog_we   = 1'b1;
                    ifc.prog_addr = 4'h3;
                    ifc.prog_data = 8'hAA;
                end
            end while (ifc.exec_valid !== 1'b1 && cycles < 8);
            check($sformatf("%s.lat[%0d]", name, n), cycles, (n == 0) ? 3 : 2);
            if (ifc.exec_valid !== 1'b1) begin
                ifc.run = 1'b0;
                return;
            end

            ins     = mem_ref[pc_ref];
            op      = ins[7:4];
            arg     = ins[3:0];
            e_jump  = (op == 4'h6) || (op == 4'h7 && ifc.zero_flag) || (op == 4'h8 && ifc.carry_flag);
            e_hlt   = (op == 4'hF);
            e_fault = !e_jump && !e_hlt && (pc_ref == 4'hF);
            e_inc   = !e_jump && !e_hlt && !e_fault;
            next_pc = e_jump ? arg : (e_inc ? pc_ref + 4'd1 : pc_ref);

            check($sformatf("%s.opcode[%0d]", name, n),  ifc.opcode,        op);
            check($sformatf("%s.operand[%0d]", name, n), ifc.operand,       arg);
            check($sformatf("%s.addr_in[%0d]", name, n), ifc.address_input, arg);
            check($sformatf("%s.jump[%0d]", name, n),    ifc.jump,          e_jump);
            check($sformatf("%s.inc[%0d]", name, n),     ifc.increment,     e_inc);
            check($sformatf("%s.halt_x[%0d]", name, n),  ifc.halted,        0);
            ifc.prog_we = 1'b0;

            tick();
            check($sformatf("%s.pc[%0d]", name, n),      ifc.current_address, next_pc);
            check($sformatf("%s.ev_off[%0d]", name, n),  ifc.exec_valid,      0);
            check($sformatf("%s.halted[%0d]", name, n),  ifc.halted,          e_hlt || e_fault);
            check($sformatf("%s.fault[%0d]", name, n),   ifc.fault,           e_fault);
            pc_ref = next_pc;
            if (e_hlt || e_fault) begin
                ref_halted = 1'b1;
                break;
            end
        end

        if (ref_halted) begin
            ifc.run = 1'b1;   // ignored while halted
            for (int k = 0; k < 3; k++) begin
                tick();
                check($sformatf("%s.hold.halted[%0d]", name, k), ifc.halted,          1);
                check($sformatf("%s.hold.pc[%0d]", name, k),     ifc.current_address, pc_ref);
                check($sformatf("%s.hold.ctl[%0d]", name, k),
                      {ifc.increment, ifc.jump, ifc.exec_valid}, 3'b000);
            end
        end else if (stop_run) begin
            for (int k = 0; k < 3; k++) begin
                tick();
                check($sformatf("%s.idle.pc[%0d]", name, k), ifc.current_address, pc_ref);
                check($sformatf("%s.idle.ctl[%0d]", name, k),
                      {ifc.increment, ifc.jump, ifc.exec_valid, ifc.halted}, 4'b0000);
            end
        end
        ifc.run = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        ifc.run        = 1'b0;
        ifc.prog_we    = 1'b0;
        ifc.prog_addr  = '0;
        ifc.prog_data  = '0;
        ifc.zero_flag  = 1'b0;
        ifc.carry_flag = 1'b0;
        pc_ref         = 4'h0;
        ref_halted     = 1'b0;
        tick();
        tick();
        check_idle_outputs("por");
        reset = 1'b0;
        tick();

        // LDI / NOP / HLT: steps at 0 and 1, halt at 2.
        write_mem(4'h0, 8'h51);
        write_mem(4'h1, 8'h00);
        write_mem(4'h2, 8'hF0);
        do_reset("basic");
        run_program("basic", 10, 0, 0, 0, 0, 0);
        check("basic.end_pc", ifc.current_address, 2);

        // Unconditional jump to 5.
        write_mem(4'h0, 8'h65);
        write_mem(4'h5, 8'hF0);
        do_reset("jmp");
        run_program("jmp", 10, 0, 0, 0, 0, 0);
        check("jmp.end_pc", ifc.current_address, 5);

        // JZ 9 / JC 9, each with the flag clear and set.
        write_mem(4'h0, 8'h79);
        write_mem(4'h1, 8'hF0);
        write_mem(4'h9, 8'hF0);
        do_reset("jz0");
        run_program("jz0", 10, 0, 0, 1, 0, 0);
        check("jz0.end_pc", ifc.current_address, 1);
        do_reset("jz1");
        run_program("jz1", 10, 0, 1, 0, 0, 0);
        check("jz1.end_pc", ifc.current_address, 9);
        write_mem(4'h0, 8'h89);
        do_reset("jc0");
        run_program("jc0", 10, 0, 1, 0, 0, 0);
        check("jc0.end_pc", ifc.current_address, 1);
        do_reset("jc1");
        run_program("jc1", 10, 0, 0, 1, 0, 0);
        check("jc1.end_pc", ifc.current_address, 9);

        // All NOPs: 15 steps, then the wrap guard faults at address 15.
        for (int a = 0; a < 16; a++) write_mem(4'(a), 8'h00);
        do_reset("wrap");
        run_program("wrap", 20, 0, 0, 0, 0, 0);
        check("wrap.fault",  ifc.fault,           1);
        check("wrap.halted", ifc.halted,          1);
        check("wrap.end_pc", ifc.current_address, 15);

        // Async reset in the middle of an incrementing EXECUTE.
        do_reset("mid");
        ifc.run = 1'b1;
        tick(); tick(); tick();
        check("mid.pre.ev",  ifc.exec_valid, 1);
        check("mid.pre.inc", ifc.increment,  1);
        reset = 1'b1;
        #1;
        check_idle_outputs("mid.async");
        tick();
        ifc.run = 1'b0;
        reset   = 1'b0;
        tick();
        check_idle_outputs("mid.after");
        check("mid.after.pc", ifc.current_address, 0);

        // Writes are blocked while running, accepted in HALT.
        write_mem(4'h3, 8'hF0);
        do_reset("blk");
        run_program("blk", 10, 0, 0, 0, 0, 1);
        check("blk.end_pc", ifc.current_address, 3);
        write_mem(4'h3, 8'hAA);
        write_mem(4'h0, 8'h63);
        write_mem(4'h4, 8'hF0);
        do_reset("wr");
        run_program("wr", 10, 0, 0, 0, 0, 0);
        check("wr.end_pc", ifc.current_address, 4);

        // Random programs and flags; run dropped before the last instruction.
        for (int t = 0; t < 8; t++) begin
            for (int a = 0; a < 16; a++) write_mem(4'(a), 8'($urandom));
            do_reset($sformatf("rnd%0d", t));
            run_program($sformatf("rnd%0d", t), 25, 1, 0, 0, 1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
